// File: rtl/uart_sat_rx.sv
`timescale 1ns/1ps
// uart_sat_rx: oversampled UART receiver, 2-flop synchronized input, small receive FIFO, RTS flow control, sticky errors.
// Latency: byte is pushed the cycle after the stop-bit sample; rx_valid rises the cycle after that.
// Backpressure: rx_ready pops the FIFO head; UART_RTS deasserts (1) at RTS_THRESH; a push into a full FIFO drops the byte and sets overrun.
// Optional build macro: UART_SAT_RX_PARITY_EN adds an even-parity bit between data and stop (11-bit frames).
module uart_sat_rx #(
   parameter int BAUD_DIV   = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int RTS_THRESH = FIFO_DEPTH - 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          UART_RX,
   output logic                          UART_RTS,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   input  logic                          err_clr,
   output logic                          frame_err,
   output logic                          overrun,
   output logic                          parity_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(BAUD_DIV);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      bitn;
   logic [7:0]      shreg;
   logic            push_req;

   logic            rx_meta;
   logic            rx_s;
   logic            rx_prev;
   logic            fall;
   logic            tick0;
   logic            frame_evt;
   logic            par_evt;
   logic            ovr_evt;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [LW-1:0]   level;
   logic [LW-1:0]   level_nxt;
   logic            full;
   logic            push_ok;
   logic            pop;

`ifdef UART_SAT_RX_PARITY_EN
   logic            bad;
`endif

   // Two-flop synchronizer plus one history flop for falling-edge detection; idle line is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= UART_RX;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign fall      = rx_prev & ~rx_s;
   assign tick0     = (cnt == '0);
   assign frame_evt = (state == STOP) && tick0 && !rx_s;

`ifdef UART_SAT_RX_PARITY_EN
   // Even parity: the parity bit equals the XOR of the data bits.
   assign par_evt   = (state == PARITY) && tick0 && (rx_s != (^shreg));
`else
   assign par_evt   = 1'b0;
`endif

   // Frame state machine: half-bit wait to the start-bit center, then one sample per bit period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bitn     <= '0;
         shreg    <= '0;
         push_req <= 1'b0;
`ifdef UART_SAT_RX_PARITY_EN
         bad      <= 1'b0;
`endif
      end else begin
         push_req <= 1'b0;
         case (state)
            IDLE: begin
               if (fall) begin
                  cnt   <= CW'(BAUD_DIV / 2 - 1);
                  state <= START;
               end
            end
            START: begin
               if (tick0) begin
                  if (rx_s) begin
                     state <= IDLE;
                  end else begin
                     state <= DATA;
                     cnt   <= CW'(BAUD_DIV - 1);
                     bitn  <= '0;
`ifdef UART_SAT_RX_PARITY_EN
                     bad   <= 1'b0;
`endif
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DATA: begin
               if (tick0) begin
                  shreg <= {rx_s, shreg[7:1]};
                  bitn  <= bitn + 3'd1;
                  cnt   <= CW'(BAUD_DIV - 1);
                  if (bitn == 3'd7) begin
`ifdef UART_SAT_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
`ifdef UART_SAT_RX_PARITY_EN
            PARITY: begin
               if (tick0) begin
                  if (par_evt) begin
                     bad <= 1'b1;
                  end
                  cnt   <= CW'(BAUD_DIV - 1);
                  state <= STOP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
`endif
            STOP: begin
               if (tick0) begin
                  if (rx_s) begin
`ifdef UART_SAT_RX_PARITY_EN
                     push_req <= !bad;
`else
                     push_req <= 1'b1;
`endif
                     state    <= IDLE;
                  end else begin
                     state <= BREAK;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO control: a full FIFO refuses the push even when a pop happens in the same cycle.
   assign full     = (level == LW'(FIFO_DEPTH));
   assign rx_valid = (level != '0);
   assign pop      = rx_valid && rx_ready;
   assign push_ok  = push_req && !full;
   assign ovr_evt  = push_req && full;
   assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
   assign fifo_level = level;

   // Next occupancy, also used so RTS tracks fifo_level without an extra cycle of lag.
   always_comb begin
      level_nxt = level;
      if (push_ok && !pop) begin
         level_nxt = level + LW'(1);
      end else if (!push_ok && pop) begin
         level_nxt = level - LW'(1);
      end
   end

   // Storage array; contents are only observable through rx_data when non-empty, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= shreg;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; RTS is a registered threshold compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         UART_RTS <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level    <= level_nxt;
         UART_RTS <= (level_nxt >= LW'(RTS_THRESH));
      end
   end

   // Sticky error flags; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= frame_evt | (frame_err & ~err_clr);
         overrun   <= ovr_evt   | (overrun   & ~err_clr);
      end
   end

`ifdef UART_SAT_RX_PARITY_EN
   // Sticky parity flag, same clear-versus-event priority as the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= par_evt | (parity_err & ~err_clr);
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
